mem_operand_fetch: RTL

- Pipeline stage directly downstream of address calculation and upstream of execute.
- Registers the address-calculated instruction bundle and issues up to two data-cache reads, one for each memory source operand that is flagged.
- Replaces the operand value with the loaded data, then presents the completed bundle to execute.
- Back-pressures address calculation through in_ready while reads are outstanding.

---
 rtl/mem_operand_fetch_if.sv | 51 +++++
 rtl/mem_operand_fetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_operand_fetch_if.sv
// Bundle, data-cache and execute handshake signals of the memory operand fetch stage.
// slave is the stage itself; master is whatever sits around it (address calc, cache, execute).
interface mem_operand_fetch_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        opcode_in;
  logic [3:0]        dest_reg_in;
  logic              mem_dest_in;
  logic [ADDR_W-1:0] addr_dest_in;
  logic              mem_src1_in;
  logic              mem_src2_in;
  logic [ADDR_W-1:0] addr_src1_in;
  logic [ADDR_W-1:0] addr_src2_in;
  logic [DATA_W-1:0] operand1_in;
  logic [DATA_W-1:0] operand2_in;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        opcode_out;
  logic [3:0]        dest_reg_out;
  logic              mem_dest_out;
  logic [ADDR_W-1:0] addr_dest_out;
  logic [DATA_W-1:0] operand1_out;
  logic [DATA_W-1:0] operand2_out;
  logic [CNT_W-1:0]  wait_cycles;

  modport master (
    output flush, in_valid, opcode_in, dest_reg_in, mem_dest_in, addr_dest_in,
           mem_src1_in, mem_src2_in, addr_src1_in, addr_src2_in, operand1_in, operand2_in,
           dc_req_ready, dc_resp_valid, dc_resp_data, out_ready,
    input  in_ready, dc_req_valid, dc_req_addr, out_valid, opcode_out, dest_reg_out,
           mem_dest_out, addr_dest_out, operand1_out, operand2_out, wait_cycles
  );

  modport slave (
    input  flush, in_valid, opcode_in, dest_reg_in, mem_dest_in, addr_dest_in,
           mem_src1_in, mem_src2_in, addr_src1_in, addr_src2_in, operand1_in, operand2_in,
           dc_req_ready, dc_resp_valid, dc_resp_data, out_ready,
    output in_ready, dc_req_valid, dc_req_addr, out_valid, opcode_out, dest_reg_out,
           mem_dest_out, addr_dest_out, operand1_out, operand2_out, wait_cycles
  );
endinterface

// File: rtl/mem_operand_fetch.sv
// Memory operand fetch stage: loads flagged source operands from the data cache before execute.
// Optional MEMFETCH_ADDR_REUSE_EN: one shared read when both sources hit the same address.
module mem_operand_fetch #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input logic clk,
  input logic reset,
  mem_operand_fetch_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, HOLD, DRAIN} stateT;

  stateT             state;
  logic [7:0]        opcodeReg;
  logic [3:0]        destRegReg;
  logic              memDestReg;
  logic [ADDR_W-1:0] addrDestReg;
  logic              srcMem2;
  logic [ADDR_W-1:0] addrSrc1;
  logic [ADDR_W-1:0] addrSrc2;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic              reqValid;
  logic [ADDR_W-1:0] reqAddr;
  logic              outValid;
  logic [CNT_W-1:0]  waitCnt;
  logic              inReady;
  logic              accept;
  logic              reuseHit;

  assign inReady = !bus.flush && (state == IDLE || (state == HOLD && bus.out_ready));
  assign accept  = bus.in_valid && inReady;

`ifdef MEMFETCH_ADDR_REUSE_EN
  assign reuseHit = srcMem2 && (addrSrc1 == addrSrc2);
`else
  assign reuseHit = 1'b0;
`endif

  // Whole stage FSM; request and output-valid flags are set on the transition into their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opcodeReg   <= '0;
      destRegReg  <= '0;
      memDestReg  <= 1'b0;
      addrDestReg <= '0;
      srcMem2     <= 1'b0;
      addrSrc1    <= '0;
      addrSrc2    <= '0;
      operand1    <= '0;
      operand2    <= '0;
      reqValid    <= 1'b0;
      reqAddr     <= '0;
      outValid    <= 1'b0;
      waitCnt     <= '0;
    end else begin
      if ((state == WAIT1 || state == WAIT2) && waitCnt != '1)
        waitCnt <= waitCnt + 1'b1;

      if (bus.flush) begin
        reqValid <= 1'b0;
        outValid <= 1'b0;
        // An already-accepted read still returns data, so DRAIN must swallow it.
        case (state)
          REQ1, REQ2:          state <= bus.dc_req_ready ? DRAIN : IDLE;
          WAIT1, WAIT2, DRAIN: state <= bus.dc_resp_valid ? IDLE : DRAIN;
          default:             state <= IDLE;
        endcase
      end else if (accept) begin
        opcodeReg   <= bus.opcode_in;
        destRegReg  <= bus.dest_reg_in;
        memDestReg  <= bus.mem_dest_in;
        addrDestReg <= bus.addr_dest_in;
        srcMem2     <= bus.mem_src2_in;
        addrSrc1    <= bus.addr_src1_in;
        addrSrc2    <= bus.addr_src2_in;
        operand1    <= bus.operand1_in;
        operand2    <= bus.operand2_in;
        if (bus.mem_src1_in) begin
          state    <= REQ1;
          reqValid <= 1'b1;
          reqAddr  <= bus.addr_src1_in;
          outValid <= 1'b0;
        end else if (bus.mem_src2_in) begin
          state    <= REQ2;
          reqValid <= 1'b1;
          reqAddr  <= bus.addr_src2_in;
          outValid <= 1'b0;
        end else begin
          state    <= HOLD;
          reqValid <= 1'b0;
          outValid <= 1'b1;
        end
      end else begin
        case (state)
          REQ1, REQ2: begin
            if (bus.dc_req_ready) begin
              state    <= (state == REQ1) ? WAIT1 : WAIT2;
              reqValid <= 1'b0;
            end
          end
          WAIT1: begin
            if (bus.dc_resp_valid) begin
              operand1 <= bus.dc_resp_data;
              if (reuseHit)
                operand2 <= bus.dc_resp_data;
              if (srcMem2 && !reuseHit) begin
                state    <= REQ2;
                reqValid <= 1'b1;
                reqAddr  <= addrSrc2;
              end else begin
                state    <= HOLD;
                outValid <= 1'b1;
              end
            end
          end
          WAIT2: begin
            if (bus.dc_resp_valid) begin
              operand2 <= bus.dc_resp_data;
              state    <= HOLD;
              outValid <= 1'b1;
            end
          end
          HOLD: begin
            if (bus.out_ready) begin
              state    <= IDLE;
              outValid <= 1'b0;
            end
          end
          DRAIN: begin
            if (bus.dc_resp_valid)
              state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready      = inReady;
  assign bus.dc_req_valid  = reqValid;
  assign bus.dc_req_addr   = reqAddr;
  assign bus.out_valid     = outValid;
  assign bus.opcode_out    = opcodeReg;
  assign bus.dest_reg_out  = destRegReg;
  assign bus.mem_dest_out  = memDestReg;
  assign bus.addr_dest_out = addrDestReg;
  assign bus.operand1_out  = operand1;
  assign bus.operand2_out  = operand2;
  assign bus.wait_cycles   = waitCnt;

endmodule
